// File: rtl/n2r_buffer_i.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// n2r_buffer_i
//
// Row-to-block converter for the multi-MAC matrix-multiply datapath.
// A ROW x COL matrix arrives one row per clock. Rows are grouped
// G = BLOCK_SIZE*NUM_CORES at a time into one of two ping-pong banks.
// When a group is complete, it is drained as COL/BLOCK_SIZE output beats.
// Each beat carries NUM_CORES BLOCK_SIZE x BLOCK_SIZE blocks, one per core.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   en             in   row-valid strobe; in_n2r_buffer is captured when high
//   in_n2r_buffer  in   WIDTH*COL bits, one matrix row, element 0 in the MSBs
//   slice_done     out  high for each cycle out_n2r_buffer carries a new beat
//   out_n2r_buffer out  WIDTH*CHUNK_SIZE*NUM_CORES bits, core 0 in the MSBs
//
// Build option:
//   N2R_BLOCK_COLMAJOR_EN  when defined, elements inside a block are packed
//                          column-major (idx = k*CHUNK + c*BS + r) rather than
//                          row-major (idx = k*CHUNK + r*BS + c).
//
// Handshake: no back-pressure. Every clk edge with en=1 in FILL captures a
// row. slice_done is a one-cycle qualifier for out_n2r_buffer. Between beats
// the output holds its last value.
// ---------------------------------------------------------------------------
module n2r_buffer_i #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int ROW        = 8,
    parameter int COL        = 6,
    parameter int NUM_CORES  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic [WIDTH*COL-1:0]                  in_n2r_buffer,
    output logic                                  slice_done,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_n2r_buffer
);

    localparam int G     = BLOCK_SIZE * NUM_CORES;   // rows per group/bank
    localparam int NB    = COL / BLOCK_SIZE;         // beats per group
    localparam int ROW_W = WIDTH * COL;
    localparam int OUT_W = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int RC_W  = $clog2(ROW + 1);
    localparam int GI_W  = (G > 1) ? $clog2(G) : 1;
    localparam int BC_W  = $clog2(NB + 1);

    // Elaboration-time sanity checks on the parameter set.
    if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_chk_chunk
        $error("CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
    end
    if ((ROW % G) != 0) begin : g_chk_row
        $error("ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
    end
    if ((COL % BLOCK_SIZE) != 0 || NB > G) begin : g_chk_col
        $error("COL must be a multiple of BLOCK_SIZE with COL/BLOCK_SIZE <= G");
    end
    if (FRAC_WIDTH > WIDTH) begin : g_chk_frac
        $error("FRAC_WIDTH must not exceed WIDTH");
    end

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [RC_W-1:0]  row_cnt;      // rows captured in the current matrix
    logic [GI_W-1:0]  grp_row;      // write row index inside the active bank
    logic             wr_bank;      // bank being filled
    logic             drain_active; // a completed bank is being emitted
    logic             drain_bank;
    logic [BC_W-1:0]  beat_cnt;     // block column currently being emitted

    logic [ROW_W-1:0] bank_q [2][G];

    logic             capture;
    logic             last_row;
    logic             last_grp_row;
    logic [OUT_W-1:0] beat_data;

    assign last_row     = (row_cnt == RC_W'(ROW - 1));
    assign last_grp_row = (grp_row == GI_W'(G - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            FILL: begin
                if (en) begin
                    capture = 1'b1;
                    if (last_row) state_d = DONE;
                end
            end
            DONE: begin
                // Re-arm only once en is seen low, so a held en never
                // restarts the matrix.
                if (!en) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // ---------------- row storage ----------------
    // Bank contents need no reset: a bank is drained only after it is
    // completely rewritten.
    always_ff @(posedge clk) begin
        if (capture) bank_q[wr_bank][grp_row] <= in_n2r_buffer;
    end

    // ---------------- beat assembly ----------------
    always_comb begin
        logic [ROW_W-1:0] row_word;
        logic [ROW_W-1:0] shifted;
        int               col;
        int               idx;
        beat_data = '0;
        row_word  = '0;
        shifted   = '0;
        col       = 0;
        idx       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                row_word = bank_q[drain_bank][GI_W'(k * BLOCK_SIZE + r)];
                for (int c = 0; c < BLOCK_SIZE; c++) begin
                    col     = int'(beat_cnt) * BLOCK_SIZE + c;
                    // Move the wanted column element into the MSBs.
                    shifted = row_word << (col * WIDTH);
`ifdef N2R_BLOCK_COLMAJOR_EN
                    idx = k * CHUNK_SIZE + c * BLOCK_SIZE + r;
`else
                    idx = k * CHUNK_SIZE + r * BLOCK_SIZE + c;
`endif
                    beat_data[OUT_W-1-idx*WIDTH -: WIDTH] = shifted[ROW_W-1 -: WIDTH];
                end
            end
        end
    end

    // ---------------- counters, drain, outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt        <= '0;
            grp_row        <= '0;
            wr_bank        <= 1'b0;
            drain_active   <= 1'b0;
            drain_bank     <= 1'b0;
            beat_cnt       <= '0;
            slice_done     <= 1'b0;
            out_n2r_buffer <= '0;
        end else begin
            slice_done <= 1'b0;

            if (drain_active) begin
                out_n2r_buffer <= beat_data;
                slice_done     <= 1'b1;
                if (beat_cnt == BC_W'(NB - 1)) begin
                    drain_active <= 1'b0;
                    beat_cnt     <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end

            // A group handoff may coincide with the final beat of the previous
            // drain; the handoff assignments below win and start the new drain.
            if (capture) begin
                if (last_grp_row) begin
                    grp_row      <= '0;
                    wr_bank      <= ~wr_bank;
                    drain_active <= 1'b1;
                    drain_bank   <= wr_bank;
                    beat_cnt     <= '0;
                end else begin
                    grp_row <= grp_row + 1'b1;
                end
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end

            if (state_q == DONE && !en) begin
                row_cnt <= '0;
                grp_row <= '0;
            end
        end
    end

endmodule

// File: tb/tb_n2r_buffer_i.sv
`timescale 1ns/1ps
module tb_n2r_buffer_i;

    localparam int WIDTH = 16;
    localparam int COL   = 6;
    localparam int IN_W  = 96;
    localparam int OUT_W = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             en;
    logic [IN_W-1:0]  in_n2r_buffer;
    logic             slice_done;
    logic [OUT_W-1:0] out_n2r_buffer;

    n2r_buffer_i dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .in_n2r_buffer  (in_n2r_buffer),
        .slice_done     (slice_done),
        .out_n2r_buffer (out_n2r_buffer)
    );

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] exp_out;
    logic [OUT_W-1:0] exp_beat [6];

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] mkrow(input int i);
        logic [IN_W-1:0] r;
        r = '0;
        for (int j = 0; j < COL; j++) r[IN_W-1-j*WIDTH -: WIDTH] = 16'((i * 6 + j) << 8);
        return r;
    endfunction

    function automatic logic [IN_W-1:0] rnd_row();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Feed all 8 rows back-to-back, then 4 more en=1 cycles of junk, checking
    // every edge. Group 0 beats on edges 4..6, group 1 beats on edges 8..10.
    task automatic feed_matrix(input string pfx);
        int pulses;
        logic exp_sd;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            en            = 1'b1;
            in_n2r_buffer = (k < 8) ? mkrow(k) : rnd_row();
            @(posedge clk);
            #1;
            exp_sd = 1'b0;
            if (k >= 4 && k <= 6) begin exp_out = exp_beat[k-4]; exp_sd = 1'b1; end
            if (k >= 8 && k <= 10) begin exp_out = exp_beat[k-5]; exp_sd = 1'b1; end
            chk($sformatf("%s_e%0d_sd", pfx, k), OUT_W'(slice_done), OUT_W'(exp_sd));
            chk($sformatf("%s_e%0d_out", pfx, k), out_n2r_buffer, exp_out);
            if (slice_done) pulses++;
        end
        chk({pfx, "_pulses"}, OUT_W'(pulses), OUT_W'(6));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pulses;
        exp_beat[0] = 128'h0000_0100_0600_0700_0C00_0D00_1200_1300;
        exp_beat[1] = 128'h0200_0300_0800_0900_0E00_0F00_1400_1500;
        exp_beat[2] = 128'h0400_0500_0A00_0B00_1000_1100_1600_1700;
        exp_beat[3] = 128'h1800_1900_1E00_1F00_2400_2500_2A00_2B00;
        exp_beat[4] = 128'h1A00_1B00_2000_2100_2600_2700_2C00_2D00;
        exp_beat[5] = 128'h1C00_1D00_2200_2300_2800_2900_2E00_2F00;

        // Reset held with random inputs.
        rst_n         = 1'b0;
        en            = 1'b0;
        in_n2r_buffer = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en            = 1'($urandom_range(0, 1));
            in_n2r_buffer = rnd_row();
            @(posedge clk);
            #1;
            chk($sformatf("rst_hold%0d_sd", i), OUT_W'(slice_done), '0);
            chk($sformatf("rst_hold%0d_out", i), out_n2r_buffer, '0);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_rel%0d_sd", i), OUT_W'(slice_done), '0);
            chk($sformatf("rst_rel%0d_out", i), out_n2r_buffer, '0);
        end

        // First matrix.
        exp_out = '0;
        feed_matrix("m1");

        // en held high in DONE: no further beats, output holds.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            en            = 1'b1;
            in_n2r_buffer = rnd_row();
            @(posedge clk);
            #1;
            if (slice_done) pulses++;
        end
        chk("done_hold_pulses", OUT_W'(pulses), '0);
        chk("done_hold_out", out_n2r_buffer, exp_beat[5]);

        // One en=0 cycle re-arms; refeed gives identical beats.
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("rearm_sd", OUT_W'(slice_done), '0);
        feed_matrix("m2");

        // Reset during beat 1 of group 0.
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            en            = 1'b1;
            in_n2r_buffer = mkrow(k);
            @(posedge clk);
            #1;
        end
        chk("mid_beat1_sd", OUT_W'(slice_done), OUT_W'(1));
        chk("mid_beat1_out", out_n2r_buffer, exp_beat[1]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sd", OUT_W'(slice_done), '0);
        chk("mid_rst_out", out_n2r_buffer, '0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (slice_done) pulses++;
        end
        chk("post_rst_pulses", OUT_W'(pulses), '0);
        chk("post_rst_out", out_n2r_buffer, '0);

        // Fresh matrix after reset.
        exp_out = '0;
        feed_matrix("m3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n2r_buffer_i.md
Name: n2r_buffer_i

Overview:
- Row-to-block converter for the multi-MAC matrix-multiply datapath.
- Accepts a ROW x COL matrix one row per clock, WIDTH-bit fixed-point elements.
- Regroups the data into BLOCK_SIZE x BLOCK_SIZE blocks and presents NUM_CORES blocks per output beat, one block per MAC core.
- Two internal banks, each holding BLOCK_SIZE*NUM_CORES rows, are used ping-pong, so input rows stream without stalls.

Parameters:
- WIDTH, 16: element width in bits.
- FRAC_WIDTH, 8: fractional bits of the element format. Informational only; data passes through unmodified.
- BLOCK_SIZE, 2: block edge length.
- CHUNK_SIZE, 4: elements per block; must equal BLOCK_SIZE*BLOCK_SIZE.
- ROW, 8: matrix rows; must be a multiple of BLOCK_SIZE*NUM_CORES.
- COL, 6: matrix columns; must be a multiple of BLOCK_SIZE, and COL/BLOCK_SIZE <= BLOCK_SIZE*NUM_CORES.
- NUM_CORES, 2: blocks per output beat.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: row-valid strobe; in_n2r_buffer is captured on every clk edge where en=1.
- in_n2r_buffer, input, WIDTH*COL: one matrix row; element 0 in the MSBs.
- slice_done, output, 1: beat-valid pulse; high for each cycle out_n2r_buffer carries a new beat.
- out_n2r_buffer, output, WIDTH*CHUNK_SIZE*NUM_CORES: NUM_CORES blocks; core 0 in the MSBs.

Behaviour:
- Reset (async, rst_n=0):
  - out_n2r_buffer=0, slice_done=0.
  - Row counter, bank select and beat counter cleared; state = FILL.
- Group definition: G = BLOCK_SIZE*NUM_CORES consecutive rows. The matrix contains ROW/G groups.
- Capture: in FILL, each en=1 edge writes the row into the active bank at row index (row_cnt mod G).
- Group handoff: after the G-th row of a group is captured:
  - the bank is handed to the drain side;
  - capture continues into the other bank on the very next edge with no bubble.
- Drain: a drained group produces COL/BLOCK_SIZE beats, beat b = block column b.
  - Beats are registered on consecutive edges t+1 .. t+COL/BLOCK_SIZE, where t is the edge that captured the group's last row.
  - Each beat is accompanied by slice_done=1; slice_done=0 otherwise.
- Beat packing: core k carries the block covering group rows k*BLOCK_SIZE+r and columns b*BLOCK_SIZE+c, for r,c in 0..BLOCK_SIZE-1.
  - Flat index idx = k*CHUNK_SIZE + r*BLOCK_SIZE + c (row-major within the block).
  - Element idx occupies out bits [OUT_W-1-idx*WIDTH -: WIDTH].
- Between beats, out_n2r_buffer holds the last beat value.
- DONE state:
  - Entered after ROW rows have been captured.
  - Further en=1 cycles are ignored; draining of the final group still completes.
  - The block re-arms (row counter 0, state FILL) on the first cycle en=0 is sampled.
  - A matrix never restarts while en stays high.
- en=0 mid-matrix: a pause only; counters hold and the matrix resumes when en returns high.
- Reset mid-operation: all partial data is discarded; no slice_done pulses follow the reset.
- The parameter constraint guarantees a drain always finishes before the next group completes. No overflow handling is required.

Optional Feature:
- Macro N2R_BLOCK_COLMAJOR_EN.
- Defined: element order within each block is column-major, idx = k*CHUNK_SIZE + c*BLOCK_SIZE + r.
- Undefined: row-major order, as specified in Behaviour.
- Timing and slice_done behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_n2r_buffer=0 and slice_done=0 throughout; release with en=0 -> outputs stay 0.
- Default parameters; rows i=0..7 on consecutive cycles, element j = (i*6+j)<<8 (row 0 = 96'h0000_0100_0200_0300_0400_0500). Beat 0 after the row-3 edge -> 128'h0000_0100_0600_0700_0C00_0D00_1200_1300 with slice_done=1.
- Same run -> beat 1 = 0200_0300_0800_0900_0E00_0F00_1400_1500; beat 2 = 0400_0500_0A00_0B00_1000_1100_1600_1700. Exactly 3 consecutive slice_done pulses per group, 6 in total.
- Second group -> beat 0 = 1800_1900_1E00_1F00_2400_2500_2A00_2B00, on the edge after row 7 is captured; row 4 continued into the second bank with no stall.
- en held high for 100 cycles after row 7 -> no further slice_done pulses; drop en for 1 cycle, then refeed the matrix -> identical 6 beats.
- Deassert rst_n during beat 1 of group 0 -> outputs 0 immediately; no later slice_done pulses. A fresh matrix after reset produces correct beats.
